pixel_clk_div: RTL

PIXEL_CLK_DIV -- requirements
Module: pixel_clk_div

---
 rtl/pixel_clk_div.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pixel_clk_div.sv
// pixel_clk_div -- programmable integer clock divider with enable pulse.
//
// Divides clk by a run-time divisor D (>= 2). Each output period is D cycles
// of clk: clk_out is low for ceil(D/2) cycles and high for floor(D/2) cycles.
// ce_out pulses once per period, in the last cycle of the period.
//
// Optional feature: define CLKDIV_SYNC_EN to enable phase re-alignment
// through the sync input. Without it, sync is accepted but ignored.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous, active-low reset
//   en         in   run request, sampled at IDLE and at each period end
//   div_in     in   [CNT_W] new divisor
//   div_valid  in   div_in is valid
//   div_ready  out  no divisor pending, a new one can be accepted
//   div_err    out  one-cycle pulse after a divisor < 2 was rejected
//   sync       in   restart the current period (CLKDIV_SYNC_EN only)
//   clk_out    out  divided clock (flop output)
//   ce_out     out  one-cycle enable per period (flop output)
//   active     out  high while the divider is in RUN
//
// Divisor handshake: a transfer happens on a cycle where div_valid and
// div_ready are both 1 at the rising clk edge. div_ready depends only on
// internal state, never combinationally on div_valid. An accepted divisor is
// held pending and takes effect only at a period boundary (or immediately
// while idle), so a period is never cut short by a divisor change.
module pixel_clk_div #(
    parameter int CNT_W    = 8,
    parameter int DIV_INIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             div_err,
    input  logic             sync,
    output logic             clk_out,
    output logic             ce_out,
    output logic             active
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_val_q, pend_val_d;
    logic             pend_q, pend_d;
    logic             clk_out_q, clk_out_d;
    logic             ce_out_q, ce_out_d;
    logic             err_q, err_d;

    logic             last;
    logic             take;
    logic             apply;
    logic [CNT_W-1:0] half_up;

`ifndef CLKDIV_SYNC_EN
    logic unused_sync;
    assign unused_sync = sync;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        err_d      = 1'b0;
        apply      = 1'b0;

        last = (cnt_q == div_q - CNT_W'(1));
        take = div_valid && !pend_q;

        // Divisors below 2 cannot form a period; reject them with a pulse.
        if (take) begin
            if (div_in < CNT_W'(2)) begin
                err_d = 1'b1;
            end else begin
                pend_d     = 1'b1;
                pend_val_d = div_in;
            end
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                apply = pend_q;
                if (en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
`ifdef CLKDIV_SYNC_EN
                // Restart the period; a ce_out due this cycle is already in
                // the output flop and still asserts.
                if (sync) begin
                    cnt_d = '0;
                    apply = pend_q;
                    if (last && !en) begin
                        state_d = IDLE;
                    end
                end else
`endif
                if (last) begin
                    cnt_d = '0;
                    apply = pend_q;
                    if (!en) begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // apply and take are mutually exclusive: take needs !pend_q.
        if (apply) begin
            div_d  = pend_val_q;
            pend_d = 1'b0;
        end

        // Outputs are registered, so derive them from next-cycle state.
        half_up   = (div_d >> 1) + {{(CNT_W-1){1'b0}}, div_d[0]};
        clk_out_d = (state_d == RUN) && (cnt_d >= half_up);
        ce_out_d  = (state_d == RUN) && (cnt_d == div_d - CNT_W'(1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= CNT_W'(DIV_INIT);
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            clk_out_q  <= 1'b0;
            ce_out_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            clk_out_q  <= clk_out_d;
            ce_out_q   <= ce_out_d;
            err_q      <= err_d;
        end
    end

    assign clk_out   = clk_out_q;
    assign ce_out    = ce_out_q;
    assign div_err   = err_q;
    assign div_ready = !pend_q;
    assign active    = (state_q == RUN);

endmodule
